// File: rtl/chase_tp_root_selector_pkg.sv
// Shared types and constant helpers for the Chase test-pattern root selector.
package chase_sel_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, SELECT, HOLD} sel_state_t;

  function automatic int unsigned pow2(input int unsigned n);
    return 32'd1 << n;
  endfunction

  function automatic int unsigned bit_len(input int unsigned v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++)
      if ((v >> i) != 0) n = i + 1;
    return n;
  endfunction

  // Lanes of the final beat that still hold codeword bits.
  function automatic logic [31:0] last_mask(input int unsigned cw_len, input int unsigned par);
    int unsigned beats, lanes;
    beats = (cw_len + par - 1) / par;
    lanes = cw_len - par * (beats - 1);
    return (lanes >= 32) ? '1 : ((32'd1 << lanes) - 32'd1);
  endfunction

  localparam int unsigned DEF_PARALLELISM    = 4;
  localparam int unsigned DEF_HD_CORRECTABLE = 3;
  localparam int unsigned DEF_SD_CORRECTABLE = 3;
  localparam int unsigned DEF_CW_LEN         = 1023;
  localparam int unsigned NUMS      = pow2(DEF_SD_CORRECTABLE);
  localparam int unsigned CNT_LEN   = bit_len(DEF_HD_CORRECTABLE + 1);
  localparam int unsigned BEATS     = (DEF_CW_LEN + DEF_PARALLELISM - 1) / DEF_PARALLELISM;
  localparam logic [31:0] LAST_MASK = last_mask(DEF_CW_LEN, DEF_PARALLELISM);

endpackage

// File: rtl/chase_tp_root_selector_if.sv
// Result handshake between the root selector (master) and the correction stage (slave).
interface chase_tp_root_selector_if #(
  parameter int unsigned SD_CORRECTABLE = 3,
  parameter int unsigned CNT_LEN        = 3
);
  logic                      out_sel_valid;
  logic                      in_sel_ready;
  logic                      out_sel_found;
  logic [SD_CORRECTABLE-1:0] out_sel_idx;
  logic [CNT_LEN-1:0]        out_sel_rootCnt;

  modport master (
    output out_sel_valid, out_sel_found, out_sel_idx, out_sel_rootCnt,
    input  in_sel_ready
  );

  modport slave (
    input  out_sel_valid, out_sel_found, out_sel_idx, out_sel_rootCnt,
    output in_sel_ready
  );
endinterface

// File: rtl/chase_tp_root_selector_acc.sv
// Per-pattern root counter: lane-masked popcount into a saturating accumulator.
module chase_tp_root_acc
  import chase_sel_pkg::*;
#(
  parameter int unsigned PARALLELISM = 4,
  parameter int unsigned CNT_LEN     = 3,
  parameter int unsigned SAT         = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr,
  input  logic                   en,
  input  logic [PARALLELISM-1:0] mask,
  input  logic [PARALLELISM-1:0] flags,
  output logic [CNT_LEN-1:0]     cnt
);
  localparam int unsigned SUM_W = CNT_LEN + bit_len(PARALLELISM);

  logic [SUM_W-1:0] sum;

  always_comb begin
    sum = SUM_W'(cnt);
    for (int unsigned l = 0; l < PARALLELISM; l++)
      sum = sum + SUM_W'(flags[l] & mask[l]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= (sum >= SUM_W'(SAT)) ? CNT_LEN'(SAT) : sum[CNT_LEN-1:0];
  end
endmodule

// File: rtl/chase_tp_root_selector.sv
// Chase root selector: counts Chien roots per test pattern, picks the lowest-metric
// pattern whose root count matches its locator degree. Optional stats: CHASE_TP_SEL_STAT_EN.
module chase_tp_root_selector
  import chase_sel_pkg::*;
#(
  parameter int unsigned PARALLELISM    = 4,
  parameter int unsigned HD_CORRECTABLE = 3,
  parameter int unsigned SD_CORRECTABLE = 3,
  parameter int unsigned CW_LEN         = 1023,
  parameter int unsigned METRIC_LEN     = 8
) (
  input  logic clk,
  input  logic in_ctr_rst_n,
  input  logic in_ctr_Srst,
  input  logic in_ctr_start,
  input  logic [pow2(SD_CORRECTABLE)*bit_len(HD_CORRECTABLE+1)-1:0] in_deg,
  input  logic [pow2(SD_CORRECTABLE)*METRIC_LEN-1:0]                in_metric,
  input  logic                                                       in_equal_valid,
  input  logic [pow2(SD_CORRECTABLE)*PARALLELISM-1:0]               in_equal,
  output logic out_busy,
`ifdef CHASE_TP_SEL_STAT_EN
  output logic [15:0] out_stat_cw_cnt,
  output logic [15:0] out_stat_fail_cnt,
`endif
  chase_tp_root_selector_if.master sel
);
  localparam int unsigned NUMS     = pow2(SD_CORRECTABLE);
  localparam int unsigned CNT_LEN  = bit_len(HD_CORRECTABLE + 1);
  localparam int unsigned BEATS    = (CW_LEN + PARALLELISM - 1) / PARALLELISM;
  localparam int unsigned BEAT_W   = (BEATS > 1) ? bit_len(BEATS - 1) : 1;
  localparam int unsigned SCAN_W   = bit_len(NUMS);
  localparam logic [31:0] LANE_MSK = last_mask(CW_LEN, PARALLELISM);

  sel_state_t                          state;
  logic [BEAT_W-1:0]                   beat;
  logic [SCAN_W-1:0]                   scan;
  logic [SD_CORRECTABLE-1:0]           scan_i;
  logic [NUMS*CNT_LEN-1:0]             deg_q;
  logic [NUMS*METRIC_LEN-1:0]          metric_q;
  logic                                best_found;
  logic [SD_CORRECTABLE-1:0]           best_idx;
  logic [METRIC_LEN-1:0]               best_metric;
  logic [CNT_LEN-1:0]                  best_cnt;
  logic [CNT_LEN-1:0]                  cnt_arr    [NUMS];
  logic [CNT_LEN-1:0]                  deg_arr    [NUMS];
  logic [METRIC_LEN-1:0]               metric_arr [NUMS];
  logic                                acc_clr, acc_en, last_beat, qual;
  logic [PARALLELISM-1:0]              lane_mask;

  assign last_beat = (beat == BEAT_W'(BEATS - 1));
  assign acc_clr   = in_ctr_Srst || (state == IDLE && in_ctr_start);
  assign acc_en    = !in_ctr_Srst && state == ACCUM && in_equal_valid;
  assign lane_mask = last_beat ? LANE_MSK[PARALLELISM-1:0] : '1;
  assign scan_i    = scan[SD_CORRECTABLE-1:0];
  assign qual      = (cnt_arr[scan_i] == deg_arr[scan_i]) &&
                     (deg_arr[scan_i] <= CNT_LEN'(HD_CORRECTABLE));

  for (genvar i = 0; i < NUMS; i++) begin : g_pat
    assign deg_arr[i]    = deg_q[i*CNT_LEN +: CNT_LEN];
    assign metric_arr[i] = metric_q[i*METRIC_LEN +: METRIC_LEN];
    chase_tp_root_acc #(
      .PARALLELISM(PARALLELISM),
      .CNT_LEN    (CNT_LEN),
      .SAT        (HD_CORRECTABLE + 1)
    ) u_acc (
      .clk  (clk),
      .rst_n(in_ctr_rst_n),
      .clr  (acc_clr),
      .en   (acc_en),
      .mask (lane_mask),
      .flags(in_equal[i*PARALLELISM +: PARALLELISM]),
      .cnt  (cnt_arr[i])
    );
  end

  // SELECT runs NUMS scan cycles plus one publish cycle, giving NUMS+1 latency.
  always_ff @(posedge clk or negedge in_ctr_rst_n) begin
    if (!in_ctr_rst_n || in_ctr_Srst) begin
      state               <= IDLE;
      beat                <= '0;
      scan                <= '0;
      deg_q               <= '0;
      metric_q            <= '0;
      best_found          <= 1'b0;
      best_idx            <= '0;
      best_metric         <= '0;
      best_cnt            <= '0;
      out_busy            <= 1'b0;
      sel.out_sel_valid   <= 1'b0;
      sel.out_sel_found   <= 1'b0;
      sel.out_sel_idx     <= '0;
      sel.out_sel_rootCnt <= '0;
`ifdef CHASE_TP_SEL_STAT_EN
      out_stat_cw_cnt     <= '0;
      out_stat_fail_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (in_ctr_start) begin
          deg_q    <= in_deg;
          metric_q <= in_metric;
          beat     <= '0;
          out_busy <= 1'b1;
          state    <= ACCUM;
        end
        ACCUM: if (in_equal_valid) begin
          if (last_beat) begin
            scan        <= '0;
            best_found  <= 1'b0;
            best_idx    <= '0;
            best_metric <= '0;
            best_cnt    <= '0;
            state       <= SELECT;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        SELECT: begin
          if (scan == SCAN_W'(NUMS)) begin
            sel.out_sel_valid   <= 1'b1;
            sel.out_sel_found   <= best_found;
            sel.out_sel_idx     <= best_idx;
            sel.out_sel_rootCnt <= best_cnt;
            state               <= HOLD;
          end else begin
            if (qual && (!best_found || metric_arr[scan_i] < best_metric)) begin
              best_found  <= 1'b1;
              best_idx    <= scan_i;
              best_metric <= metric_arr[scan_i];
              best_cnt    <= cnt_arr[scan_i];
            end
            scan <= scan + 1'b1;
          end
        end
        HOLD: if (sel.in_sel_ready) begin
`ifdef CHASE_TP_SEL_STAT_EN
          out_stat_cw_cnt <= out_stat_cw_cnt + 16'd1;
          if (!sel.out_sel_found) out_stat_fail_cnt <= out_stat_fail_cnt + 16'd1;
`endif
          sel.out_sel_valid   <= 1'b0;
          sel.out_sel_found   <= 1'b0;
          sel.out_sel_idx     <= '0;
          sel.out_sel_rootCnt <= '0;
          out_busy            <= 1'b0;
          state               <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chase_tp_root_selector.sv
// Scoreboard bench for chase_tp_root_selector; stats checked when CHASE_TP_SEL_STAT_EN is set.
module tb_chase_tp_root_selector;
  localparam int unsigned PAR   = 4;
  localparam int unsigned NUMS  = 8;
  localparam int unsigned CL    = 3;
  localparam int unsigned ML    = 8;
  localparam int unsigned BEATS = 256;
  localparam int unsigned NONE  = 9999;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
    logic [2:0] cnt;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n, srst, start, eq_valid;
  logic [NUMS*CL-1:0]   in_deg;
  logic [NUMS*ML-1:0]   in_metric;
  logic [NUMS*PAR-1:0]  in_equal;
  logic                 busy;
`ifdef CHASE_TP_SEL_STAT_EN
  logic [15:0]          cw_cnt, fail_cnt;
`endif

  chase_tp_root_selector_if #(.SD_CORRECTABLE(3), .CNT_LEN(CL)) sel ();

  chase_tp_root_selector #(
    .PARALLELISM(PAR), .HD_CORRECTABLE(3), .SD_CORRECTABLE(3),
    .CW_LEN(1023), .METRIC_LEN(ML)
  ) dut (
    .clk           (clk),
    .in_ctr_rst_n  (rst_n),
    .in_ctr_Srst   (srst),
    .in_ctr_start  (start),
    .in_deg        (in_deg),
    .in_metric     (in_metric),
    .in_equal_valid(eq_valid),
    .in_equal      (in_equal),
    .out_busy      (busy),
`ifdef CHASE_TP_SEL_STAT_EN
    .out_stat_cw_cnt  (cw_cnt),
    .out_stat_fail_cnt(fail_cnt),
`endif
    .sel           (sel)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0, errors = 0;
  exp_t        sb[$];
  logic [NUMS*PAR-1:0] flags_mem [BEATS];
  logic [CL-1:0]       deg_v [NUMS];
  logic [ML-1:0]       met_v [NUMS];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every presented result against the scoreboard head, pop on handshake.
  always @(negedge clk) begin
    if (rst_n && sel.out_sel_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid=1 expected no result at %0t", $time);
      end else begin
        chk("found",   32'(sel.out_sel_found),   32'(sb[0].found));
        chk("idx",     32'(sel.out_sel_idx),     32'(sb[0].idx));
        chk("rootCnt", 32'(sel.out_sel_rootCnt), 32'(sb[0].cnt));
        if (sel.in_sel_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic clear_cw();
    for (int unsigned b = 0; b < BEATS; b++) flags_mem[b] = '0;
    for (int unsigned p = 0; p < NUMS; p++) begin
      deg_v[p] = 3'd3;
      met_v[p] = 8'h00;
    end
  endtask

  task automatic set_flag(input int unsigned p, input int unsigned b, input int unsigned l);
    flags_mem[b][p*PAR+l] = 1'b1;
  endtask

  task automatic start_cw();
    @(posedge clk); #1;
    for (int unsigned p = 0; p < NUMS; p++) begin
      in_deg[p*CL +: CL]    = deg_v[p];
      in_metric[p*ML +: ML] = met_v[p];
    end
    start = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
    in_deg    = '0;
    in_metric = '1;
  endtask

  // Streams all beats with periodic valid-low gaps carrying junk flags.
  task automatic stream(input int unsigned srst_at, input int unsigned start_at);
    for (int unsigned b = 0; b < BEATS; b++) begin
      if (b % 37 == 5) begin
        in_equal = '1; eq_valid = 1'b0;
        @(posedge clk); #1;
      end
      in_equal = flags_mem[b]; eq_valid = 1'b1;
      if (b == start_at) begin start = 1'b1; in_deg = '0; end
      if (b == srst_at) srst = 1'b1;
      @(posedge clk); #1;
      eq_valid = 1'b0; start = 1'b0; in_equal = '0;
      if (b == srst_at) begin
        srst = 1'b0;
        chk("busy_after_srst", 32'(busy), 0);
        return;
      end
    end
  endtask

  task automatic finish_cw(input int unsigned hold);
    int unsigned n;
    n = 0;
    while (!sel.out_sel_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 9);
    repeat (hold) begin @(posedge clk); #1; end
    sel.in_sel_ready = 1'b1;
    @(posedge clk); #1;
    sel.in_sel_ready = 1'b0;
    chk("valid_after_hs", 32'(sel.out_sel_valid), 0);
    chk("busy_after_hs",  32'(busy), 0);
  endtask

  task automatic run_cw(input exp_t e, input int unsigned hold, input int unsigned start_at);
    sb.push_back(e);
    start_cw();
    stream(NONE, start_at);
    finish_cw(hold);
  endtask

  task automatic setup_t1();
    clear_cw();
    for (int unsigned p = 0; p < NUMS; p++) begin
      met_v[p] = 8'(8 - p);
      if (p != 5) set_flag(p, 5, 0);
    end
    deg_v[5] = 3'd2;
    set_flag(5, 10, 1);
    set_flag(5, 200, 3);
  endtask

  task automatic setup_t2();
    clear_cw();
    for (int unsigned p = 0; p < NUMS; p++) met_v[p] = 8'h01;
    deg_v[2] = 3'd1; met_v[2] = 8'h20; set_flag(2, 30, 2);
    deg_v[6] = 3'd1; met_v[6] = 8'h20; set_flag(6, 254, 3);
  endtask

  task automatic setup_t3();
    clear_cw();
    deg_v[0] = 3'd1;
    set_flag(0, 255, 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; srst = 1'b0; start = 1'b0; eq_valid = 1'b0;
    in_deg = '0; in_metric = '0; in_equal = '0; sel.in_sel_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",    32'(busy), 0);
    chk("rst_valid",   32'(sel.out_sel_valid), 0);
    chk("rst_found",   32'(sel.out_sel_found), 0);
    chk("rst_idx",     32'(sel.out_sel_idx), 0);
    chk("rst_rootCnt", 32'(sel.out_sel_rootCnt), 0);
    rst_n = 1'b1;
    sel.in_sel_ready = 1'b1;
    @(posedge clk); #1;
    sel.in_sel_ready = 1'b0;
    chk("idle_ready_ignored", 32'(busy), 0);

    setup_t1(); run_cw('{found: 1'b1, idx: 3'd5, cnt: 3'd2}, 0, NONE);
    setup_t1(); run_cw('{found: 1'b1, idx: 3'd5, cnt: 3'd2}, 2, 128);
    setup_t2(); run_cw('{found: 1'b1, idx: 3'd2, cnt: 3'd1}, 0, NONE);

    // Saturation, degree above HD, and a zero-degree error-free pattern.
    clear_cw();
    for (int unsigned p = 0; p < NUMS; p++) met_v[p] = 8'h60;
    met_v[1] = 8'h00;
    for (int unsigned l = 0; l < PAR; l++) set_flag(1, 0, l);
    set_flag(1, 1, 0);
    deg_v[4] = 3'd4; met_v[4] = 8'h00;
    for (int unsigned l = 0; l < PAR; l++) set_flag(4, 2, l);
    deg_v[7] = 3'd0; met_v[7] = 8'h50;
    run_cw('{found: 1'b1, idx: 3'd7, cnt: 3'd0}, 20, NONE);

    setup_t3(); run_cw('{found: 1'b0, idx: 3'd0, cnt: 3'd0}, 0, NONE);

    // Srst mid-window: no result may follow.
    setup_t1();
    start_cw();
    stream(100, 50);
    repeat (30) begin @(posedge clk); #1; end
    chk("srst_no_valid", 32'(sel.out_sel_valid), 0);
    chk("srst_busy",     32'(busy), 0);

    // Async reset during SELECT.
    setup_t2();
    start_cw();
    stream(NONE, NONE);
    repeat (3) @(posedge clk);
    #3;
    chk("select_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy",  32'(busy), 0);
    chk("arst_valid", 32'(sel.out_sel_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    chk("arst_no_valid", 32'(sel.out_sel_valid), 0);
`ifdef CHASE_TP_SEL_STAT_EN
    chk("stat_cw_cleared",   32'(cw_cnt), 0);
    chk("stat_fail_cleared", 32'(fail_cnt), 0);
`endif

    setup_t1(); run_cw('{found: 1'b1, idx: 3'd5, cnt: 3'd2}, 0, NONE);
    setup_t3(); run_cw('{found: 1'b0, idx: 3'd0, cnt: 3'd0}, 0, NONE);
    setup_t2(); run_cw('{found: 1'b1, idx: 3'd2, cnt: 3'd1}, 0, NONE);
`ifdef CHASE_TP_SEL_STAT_EN
    chk("stat_cw_cnt",   32'(cw_cnt), 3);
    chk("stat_fail_cnt", 32'(fail_cnt), 1);
`endif

    repeat (2) @(posedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
